sram_ctrl: RTL and testbench

SRAM_CTRL -- requirements
Module: sram_ctrl

---
 rtl/sram_ctrl_pkg.sv | 17 +
 rtl/sram_phase_counter.sv | 36 +++
 rtl/sram_ctrl.sv | 162 ++++++++++++++++
 tb/tb_sram_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the 32-bit CPU to 16-bit SRAM bridge.
package sram_ctrl_pkg;

   localparam int unsigned SRAM_DW = 16;
   localparam int unsigned SRAM_AW = 18;
   localparam int unsigned CPU_DW  = 32;

   localparam logic [31:0] BASE_ADDR_DEFAULT = 32'd1024;

   typedef enum logic [1:0] {
      StIdle,
      StLo,
      StHi,
      StDone
   } sram_state_e;

endpackage

// File: rtl/sram_phase_counter.sv
// Phase counter for one SRAM half-access; tc_o flags the last cycle of the half.
module sram_phase_counter #(
   parameter int unsigned WIDTH    = 1,
   parameter int unsigned TERMINAL = 1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   input  logic enable_i,
   output logic tc_o
);

   localparam logic [WIDTH-1:0] TcVal = WIDTH'(TERMINAL);

   logic [WIDTH-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (enable_i) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tc_o = (count_q == TcVal);

endmodule

// File: rtl/sram_ctrl.sv
// Splits each 32-bit CPU access into two 16-bit SRAM half-accesses (low then high).
// Define MEM_ALIGN_CHECK_EN to reject misaligned or below-base requests via align_err.
module sram_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int unsigned HALF_CYCLES = 2,
   parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rd_en,
   input  logic                 wr_en,
   input  logic [31:0]          address,
   input  logic [CPU_DW-1:0]    write_data,
   output logic [CPU_DW-1:0]    read_data,
   output logic                 ready,
   output logic                 align_err,
   output logic [SRAM_AW-1:0]   sram_addr,
   output logic [SRAM_DW-1:0]   sram_dq_out,
   input  logic [SRAM_DW-1:0]   sram_dq_in,
   output logic                 sram_dq_oe,
   output logic                 sram_we_n
);

   localparam int unsigned CntW = (HALF_CYCLES > 2) ? $clog2(HALF_CYCLES) : 1;

   sram_state_e state_q, state_d;

   logic                 op_wr_q, op_wr_d;
   logic [SRAM_AW-2:0]   half_addr_q, half_addr_d;
   logic [CPU_DW-1:0]    wdata_q, wdata_d;
   logic [CPU_DW-1:0]    rdata_q, rdata_d;
   logic [31:0]          offset;
   logic                 req;
   logic                 reject;
   logic                 phase_tc;
   logic                 phase_clr;
   logic                 phase_en;
   logic                 unused_bits;

   assign req         = rd_en | wr_en;
   assign offset      = address - BASE_ADDR;
   assign unused_bits = ^{offset[31:19], offset[1:0]};

`ifdef MEM_ALIGN_CHECK_EN
   logic err_q, err_d;
   assign reject    = (address[1:0] != 2'b00) || (address < BASE_ADDR);
   assign align_err = (state_q == StDone) && err_q;
`else
   assign reject    = 1'b0;
   assign align_err = 1'b0;
`endif

   // Counter restarts on every state change so each half sees a fresh count.
   assign phase_clr = (state_d != state_q);
   assign phase_en  = (state_q == StLo) || (state_q == StHi);

   sram_phase_counter #(
      .WIDTH    (CntW),
      .TERMINAL (HALF_CYCLES - 1)
   ) u_phase (
      .clk_i    (clk),
      .rst_i    (rst),
      .clear_i  (phase_clr),
      .enable_i (phase_en),
      .tc_o     (phase_tc)
   );

   always_comb begin
      state_d     = state_q;
      op_wr_d     = op_wr_q;
      half_addr_d = half_addr_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
`ifdef MEM_ALIGN_CHECK_EN
      err_d       = err_q;
`endif
      ready       = 1'b0;
      sram_addr   = '0;
      sram_dq_out = '0;
      sram_dq_oe  = 1'b0;
      sram_we_n   = 1'b1;

      unique case (state_q)
         StIdle: begin
            ready = ~req;
            if (req) begin
               // Operands are latched so the pipeline may change them mid-access.
               op_wr_d     = wr_en;
               half_addr_d = offset[18:2];
               wdata_d     = write_data;
`ifdef MEM_ALIGN_CHECK_EN
               err_d       = reject;
`endif
               state_d     = reject ? StDone : StLo;
            end
         end
         StLo: begin
            sram_addr = {half_addr_q, 1'b0};
            if (op_wr_q) begin
               sram_dq_oe  = 1'b1;
               sram_dq_out = wdata_q[15:0];
               sram_we_n   = phase_tc;
            end
            if (phase_tc) begin
               state_d = StHi;
               if (!op_wr_q) begin
                  rdata_d[15:0] = sram_dq_in;
               end
            end
         end
         StHi: begin
            sram_addr = {half_addr_q, 1'b1};
            if (op_wr_q) begin
               sram_dq_oe  = 1'b1;
               sram_dq_out = wdata_q[31:16];
               sram_we_n   = phase_tc;
            end
            if (phase_tc) begin
               state_d = StDone;
               if (!op_wr_q) begin
                  rdata_d[31:16] = sram_dq_in;
               end
            end
         end
         StDone: begin
            ready   = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         op_wr_q     <= 1'b0;
         half_addr_q <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         op_wr_q     <= op_wr_d;
         half_addr_q <= half_addr_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
      end
   end

`ifdef MEM_ALIGN_CHECK_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end
`endif

   assign read_data = rdata_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl with a small behavioural SRAM; HALF_CYCLES = 2.
module tb_sram_ctrl;

   logic        clk;
   logic        rst;
   logic        rd_en;
   logic        wr_en;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        ready;
   logic        align_err;
   logic [17:0] sram_addr;
   logic [15:0] sram_dq_out;
   logic [15:0] sram_dq_in;
   logic        sram_dq_oe;
   logic        sram_we_n;

   int unsigned checks = 0;
   int unsigned errors = 0;

   // SRAM model: writes on the strobe; preload port used only while the DUT is idle.
   logic [15:0] mem [0:63];
   logic        pre_en;
   logic [5:0]  pre_a;
   logic [15:0] pre_d;

   always @(posedge clk) begin
      if (!sram_we_n) begin
         mem[sram_addr[5:0]] <= sram_dq_out;
      end else if (pre_en) begin
         mem[pre_a] <= pre_d;
      end
   end
   assign sram_dq_in = mem[sram_addr[5:0]];

   sram_ctrl #(
      .HALF_CYCLES (2),
      .BASE_ADDR   (32'd1024)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rd_en       (rd_en),
      .wr_en       (wr_en),
      .address     (address),
      .write_data  (write_data),
      .read_data   (read_data),
      .ready       (ready),
      .align_err   (align_err),
      .sram_addr   (sram_addr),
      .sram_dq_out (sram_dq_out),
      .sram_dq_in  (sram_dq_in),
      .sram_dq_oe  (sram_dq_oe),
      .sram_we_n   (sram_we_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Each cycle is viewed from its low phase: inputs change at the negedge, sample 1 later.
   task automatic step();
      @(negedge clk);
   endtask

   // Full 6-cycle access from an idle machine; request dropped after cycle 0.
   task automatic access(input string tag, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic [17:0] ha,
                         input logic exp_wr);
      step();
      rd_en = rd; wr_en = wr; address = addr; write_data = wd;
      #1;
      check({tag, " c0 ready"}, {31'd0, ready}, 32'd0);
      for (int c = 1; c <= 5; c++) begin
         step();
         if (c == 1) begin
            rd_en = 1'b0; wr_en = 1'b0;
         end
         #1;
         check($sformatf("%s c%0d ready", tag, c), {31'd0, ready}, (c == 5) ? 32'd1 : 32'd0);
         if (c <= 4) begin
            check($sformatf("%s c%0d addr", tag, c), {14'd0, sram_addr},
                  {14'd0, ha} + ((c > 2) ? 32'd1 : 32'd0));
            check($sformatf("%s c%0d we_n", tag, c), {31'd0, sram_we_n},
                  (exp_wr && (c % 2 == 1)) ? 32'd0 : 32'd1);
            check($sformatf("%s c%0d oe", tag, c), {31'd0, sram_dq_oe}, {31'd0, exp_wr});
            if (exp_wr) begin
               check($sformatf("%s c%0d dq", tag, c), {16'd0, sram_dq_out},
                     (c <= 2) ? {16'd0, wd[15:0]} : {16'd0, wd[31:16]});
            end
         end else begin
            check({tag, " c5 rdata"}, read_data, exp_rd);
            check({tag, " c5 align"}, {31'd0, align_err}, 32'd0);
         end
      end
   endtask

   initial begin
      rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
      pre_en = 1'b0; pre_a = '0; pre_d = '0;
      #1;
      check("rst ready", {31'd0, ready}, 32'd1);
      check("rst rdata", read_data, 32'd0);
      check("rst align", {31'd0, align_err}, 32'd0);
      check("rst addr", {14'd0, sram_addr}, 32'd0);
      check("rst dq", {16'd0, sram_dq_out}, 32'd0);
      check("rst oe", {31'd0, sram_dq_oe}, 32'd0);
      check("rst we_n", {31'd0, sram_we_n}, 32'd1);

      // Preload half-words 2,3 for the 1028 read.
      step(); pre_en = 1'b1; pre_a = 6'd2; pre_d = 16'h1111;
      step(); pre_a = 6'd3; pre_d = 16'h2222;
      step(); pre_en = 1'b0;
      step(); rst = 1'b0;

      // Write 0xDEADBEEF to 1024 -> half-words 0,1.
      access("wr", 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 32'h0, 18'd0, 1'b1);
      check("wr mem0", {16'd0, mem[0]}, 32'h0000BEEF);
      check("wr mem1", {16'd0, mem[1]}, 32'h0000DEAD);

      // Read back from 1024.
      access("rd", 1'b1, 1'b0, 32'd1024, 32'h0, 32'hDEADBEEF, 18'd0, 1'b0);

      // Both requests: write wins, read_data untouched.
      access("both", 1'b1, 1'b1, 32'd1032, 32'h12345678, 32'hDEADBEEF, 18'd4, 1'b1);
      check("both mem4", {16'd0, mem[4]}, 32'h00005678);
      check("both mem5", {16'd0, mem[5]}, 32'h00001234);

      // Reset during cycle 2 of a write to 1040.
      step(); wr_en = 1'b1; address = 32'd1040; write_data = 32'hAAAA5555;
      #1 check("rstw c0 ready", {31'd0, ready}, 32'd0);
      step(); wr_en = 1'b0;
      #1 check("rstw c1 we_n", {31'd0, sram_we_n}, 32'd0);
      step(); rst = 1'b1;
      #1;
      check("rstw we_n", {31'd0, sram_we_n}, 32'd1);
      check("rstw oe", {31'd0, sram_dq_oe}, 32'd0);
      check("rstw ready", {31'd0, ready}, 32'd1);
      check("rstw addr", {14'd0, sram_addr}, 32'd0);
      check("rstw rdata", read_data, 32'd0);
      step(); rst = 1'b0;
      #1;
      check("rstw idle ready", {31'd0, ready}, 32'd1);
      check("rstw mem8", {16'd0, mem[8]}, 32'h00005555);
      access("rd2", 1'b1, 1'b0, 32'd1024, 32'h0, 32'hDEADBEEF, 18'd0, 1'b0);

      // Back-to-back reads 1028 then 1032; rd_en held through the first DONE.
      step(); rd_en = 1'b1; address = 32'd1028;
      #1 check("b2b c0 ready", {31'd0, ready}, 32'd0);
      for (int c = 1; c <= 11; c++) begin
         logic [31:0] exp_a;
         step();
         if (c == 5) address = 32'd1032;
         if (c == 7) rd_en = 1'b0;
         #1;
         check($sformatf("b2b c%0d ready", c), {31'd0, ready},
               (c == 5 || c == 11) ? 32'd1 : 32'd0);
         case (c)
            1, 2:    exp_a = 32'd2;
            3, 4:    exp_a = 32'd3;
            7, 8:    exp_a = 32'd4;
            9, 10:   exp_a = 32'd5;
            default: exp_a = 32'd0;
         endcase
         check($sformatf("b2b c%0d addr", c), {14'd0, sram_addr}, exp_a);
         if (c == 5) check("b2b rdata1", read_data, 32'h22221111);
         if (c == 11) check("b2b rdata2", read_data, 32'h12345678);
      end

`ifdef MEM_ALIGN_CHECK_EN
      // Misaligned read is rejected straight to DONE.
      step(); rd_en = 1'b1; address = 32'd1026;
      #1;
      check("al c0 ready", {31'd0, ready}, 32'd0);
      check("al c0 we_n", {31'd0, sram_we_n}, 32'd1);
      step(); rd_en = 1'b0;
      #1;
      check("al c1 ready", {31'd0, ready}, 32'd1);
      check("al c1 err", {31'd0, align_err}, 32'd1);
      check("al c1 we_n", {31'd0, sram_we_n}, 32'd1);
      check("al c1 rdata", read_data, 32'h12345678);
      step();
      #1;
      check("al c2 err", {31'd0, align_err}, 32'd0);
      check("al c2 ready", {31'd0, ready}, 32'd1);
      // Below-base address is rejected too.
      step(); rd_en = 1'b1; address = 32'd1020;
      step(); rd_en = 1'b0;
      #1;
      check("lo c1 err", {31'd0, align_err}, 32'd1);
      check("lo c1 rdata", read_data, 32'h12345678);
`else
      // Without the check, low address bits are ignored.
      access("mis", 1'b1, 1'b0, 32'd1026, 32'h0, 32'hDEADBEEF, 18'd0, 1'b0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
